logicnet_layer_sched: RTL and testbench



---
 rtl/logicnet_pkg.sv | 27 ++
 rtl/logicnet_lut_bank.sv | 26 ++
 rtl/logicnet_layer_sched.sv | 99 +++++++++
 tb/tb_logicnet_layer_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logicnet_pkg.sv
// Shared constants, FSM state type and sizing helpers for the LogicNets layer scheduler.
package logicnet_pkg;

    localparam int NRN_IN_W  = 6;
    localparam int NRN_OUT_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    function automatic int sched_steps(input int n, input int l);
        return (l > 0) ? n / l : 1;
    endfunction

    function automatic int cnt_width(input int n, input int l);
        int s;
        s = sched_steps(n, l);
        return (s > 1) ? $clog2(s) : 1;
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/logicnet_lut_bank.sv
// Per-neuron 6-in/2-out truth tables, read combinationally for LANES consecutive neurons.
module logicnet_lut_bank
    import logicnet_pkg::*;
#(
    parameter int N_NEURONS = 128,
    parameter int LANES     = 1,
    parameter logic [N_NEURONS*(2**NRN_IN_W)*NRN_OUT_W-1:0] TABLES = '0
) (
    input  logic [sel_width(N_NEURONS)-1:0] lut_sel_i,
    input  logic [NRN_IN_W*LANES-1:0]       lut_addr_i,
    output logic [NRN_OUT_W*LANES-1:0]      lut_data_o
);

    localparam int TBL_W = (2**NRN_IN_W) * NRN_OUT_W;

    // Table of neuron n occupies TABLES[n*TBL_W +: TBL_W], entry a at bit a*NRN_OUT_W.
    always_comb begin
        lut_data_o = '0;
        for (int l = 0; l < LANES; l++) begin
            lut_data_o[l*NRN_OUT_W +: NRN_OUT_W] =
                TABLES[(int'(lut_sel_i) + l) * TBL_W
                       + int'(lut_addr_i[l*NRN_IN_W +: NRN_IN_W]) * NRN_OUT_W +: NRN_OUT_W];
        end
    end

endmodule

// File: rtl/logicnet_layer_sched.sv
// Time-multiplexed evaluation of one LogicNets layer through LANES shared LUT ports.
module logicnet_layer_sched
    import logicnet_pkg::*;
#(
    parameter  int N_NEURONS = 128,
    parameter  int LANES     = 1,
    localparam int SEL_W     = sel_width(N_NEURONS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NRN_IN_W*N_NEURONS-1:0] in_data,
    output logic [SEL_W-1:0]              lut_sel,
    output logic [NRN_IN_W*LANES-1:0]     lut_addr,
    input  logic [NRN_OUT_W*LANES-1:0]    lut_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NRN_OUT_W*N_NEURONS-1:0] out_data,
    output logic                          busy
);

    localparam int STEPS = sched_steps(N_NEURONS, LANES);
    localparam int CNT_W = cnt_width(N_NEURONS, LANES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    if (LANES < 1 || LANES > N_NEURONS || (N_NEURONS % LANES) != 0) begin : g_bad_cfg
        $error("logicnet_layer_sched: N_NEURONS must be a positive multiple of LANES");
    end

    sched_state_e                          state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [NRN_IN_W*N_NEURONS-1:0]         in_q, in_d;
    logic [NRN_OUT_W*N_NEURONS-1:0]        out_q, out_d;
    logic                                  eval;
    logic [SEL_W-1:0]                      base;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_q    <= in_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_d      = in_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    in_d    = in_data;
                    cnt_d   = '0;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                busy = 1'b1;
                // cnt parks on the final step rather than wrapping
                if (cnt_q == CNT_LAST) state_d = ST_DONE;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign eval     = (state_q == ST_EVAL);
    // Outside EVAL the lanes point at neurons 0..LANES-1 and lut_data is ignored.
    assign base     = eval ? SEL_W'(int'(cnt_q) * LANES) : '0;
    assign lut_sel  = base;
    assign out_data = out_q;

    always_comb begin
        lut_addr = '0;
        out_d    = out_q;
        for (int l = 0; l < LANES; l++) begin
            lut_addr[l*NRN_IN_W +: NRN_IN_W] = in_q[(int'(base) + l) * NRN_IN_W +: NRN_IN_W];
            if (eval) begin
                out_d[(int'(base) + l) * NRN_OUT_W +: NRN_OUT_W] = lut_data[l*NRN_OUT_W +: NRN_OUT_W];
            end
        end
    end

endmodule

// File: tb/tb_logicnet_layer_sched.sv
// Scoreboard bench: three N=4 schedulers (LANES 1, 2, 4) share stimulus; LUT returns addr[5:4].
module tb_logicnet_layer_sched;

    localparam int N = 4;
    localparam logic [23:0] VEC_A = 24'b000000_100000_010000_110000;
    localparam logic [7:0]  RES_A = 8'b00_10_01_11;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [23:0] in_data   = '0;
    int          cyc       = 0;
    int          n_chk     = 0;
    int          n_pass    = 0;

    logic [2:0]       rdy_w, ov_w, busy_w;
    logic [2:0][7:0]  od_w;
    logic [2:0][1:0]  sel_w;
    logic [2:0][5:0]  a0_w;
    logic [5:0]       la1;
    logic [11:0]      la2;
    logic [23:0]      la4;
    logic [1:0]       ld1;
    logic [3:0]       ld2;
    logic [7:0]       ld4;

    function automatic logic [7:0] model(input logic [23:0] v);
        logic [7:0] r;
        r = '0;
        for (int n = 0; n < N; n++) r[2*n +: 2] = v[6*n+4 +: 2];
        return r;
    endfunction

    function automatic logic [511:0] mk_tbl();
        logic [511:0] t;
        logic [5:0]   a;
        t = '0;
        for (int n = 0; n < N; n++) begin
            for (int i = 0; i < 64; i++) begin
                a = 6'(i);
                t[n*128 + i*2 +: 2] = a[5:4];
            end
        end
        return t;
    endfunction

    localparam logic [511:0] TBL = mk_tbl();

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logicnet_layer_sched #(.N_NEURONS(N), .LANES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[0]), .in_data(in_data),
        .lut_sel(sel_w[0]), .lut_addr(la1), .lut_data(ld1), .out_valid(ov_w[0]),
        .out_ready(out_ready), .out_data(od_w[0]), .busy(busy_w[0]));

    logicnet_layer_sched #(.N_NEURONS(N), .LANES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[1]), .in_data(in_data),
        .lut_sel(sel_w[1]), .lut_addr(la2), .lut_data(ld2), .out_valid(ov_w[1]),
        .out_ready(out_ready), .out_data(od_w[1]), .busy(busy_w[1]));

    logicnet_layer_sched #(.N_NEURONS(N), .LANES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w[2]), .in_data(in_data),
        .lut_sel(sel_w[2]), .lut_addr(la4), .lut_data(ld4), .out_valid(ov_w[2]),
        .out_ready(out_ready), .out_data(od_w[2]), .busy(busy_w[2]));

    logicnet_lut_bank #(.N_NEURONS(N), .LANES(2), .TABLES(TBL)) u_bank2 (
        .lut_sel_i(sel_w[1]), .lut_addr_i(la2), .lut_data_o(ld2));

    assign ld1 = la1[5:4];
    assign ld4 = {la4[23:22], la4[17:16], la4[11:10], la4[5:4]};
    assign a0_w[0] = la1;
    assign a0_w[1] = la2[5:0];
    assign a0_w[2] = la4[5:0];

    for (genvar g = 0; g < 3; g++) begin : g_mon
        localparam int L = 1 << g;
        localparam int S = N / L;
        logic [7:0]  exp_q[$];
        logic [23:0] vec      = '0;
        logic        ov_p     = 1'b0;
        logic        hold_p   = 1'b0;
        logic [7:0]  hold_d   = '0;
        int          acc_edge = 0;
        int          bcnt     = 0;

        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                bcnt   = 0;
                ov_p   = 1'b0;
                hold_p = 1'b0;
            end else begin
                if (busy_w[g]) begin
                    chk($sformatf("sel%0d", g), 32'(sel_w[g]), 32'((bcnt % S) * L));
                    chk($sformatf("addr%0d", g), 32'(a0_w[g]), 32'(vec[6*((bcnt % S)*L) +: 6]));
                    bcnt++;
                end
                if (ov_w[g] && !ov_p) begin
                    chk($sformatf("latency%0d", g), 32'(cyc - acc_edge), 32'(S));
                    chk($sformatf("busy_cycles%0d", g), 32'(bcnt), 32'(S));
                end
                if (hold_p) begin
                    chk($sformatf("hold_valid%0d", g), 32'(ov_w[g]), 32'd1);
                    chk($sformatf("hold_data%0d", g), 32'(od_w[g]), 32'(hold_d));
                end
                if (ov_w[g] && out_ready) begin
                    if (exp_q.size() == 0) chk($sformatf("unexpected_out%0d", g), 32'd1, 32'd0);
                    else chk($sformatf("out%0d", g), 32'(od_w[g]), 32'(exp_q.pop_front()));
                end
                hold_p = ov_w[g] && !out_ready;
                hold_d = od_w[g];
                ov_p   = ov_w[g];
                if (in_valid && rdy_w[g]) begin
                    exp_q.push_back(model(in_data));
                    vec      = in_data;
                    acc_edge = cyc + 1;
                    bcnt     = 0;
                end
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (rdy_w != 3'b111 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (rdy_w != 3'b111) chk("idle_timeout", 32'(rdy_w), 32'h7);
    endtask

    task automatic wait_ov(input int g);
        int t;
        t = 0;
        @(negedge clk);
        while (!ov_w[g] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ov_w[g]) chk("out_valid_timeout", 32'(ov_w[g]), 32'd1);
    endtask

    task automatic send(input logic [23:0] v);
        @(posedge clk);
        #1;
        in_data  = v;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_outs(input string tag);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_rdy%0d", tag, g), 32'(rdy_w[g]), 32'd1);
            chk($sformatf("%s_ov%0d", tag, g), 32'(ov_w[g]), 32'd0);
            chk($sformatf("%s_busy%0d", tag, g), 32'(busy_w[g]), 32'd0);
            chk($sformatf("%s_sel%0d", tag, g), 32'(sel_w[g]), 32'd0);
            chk($sformatf("%s_addr%0d", tag, g), 32'(a0_w[g]), 32'd0);
            chk($sformatf("%s_data%0d", tag, g), 32'(od_w[g]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] vb, vc, vd;
        logic [23:0] ve[3];
        int acc[3];
        int k, t;

        vb = 24'($urandom);
        vc = 24'($urandom);
        vd = 24'($urandom);
        for (int i = 0; i < 3; i++) ve[i] = 24'($urandom);
        acc = '{0, 0, 0};

        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("reset");
        rst_n = 1'b1;

        // single vector, all three lane counts
        send(VEC_A);
        wait_ov(0);
        chk("vecA_data", 32'(od_w[0]), 32'(RES_A));

        // downstream stall with a second vector waiting
        wait_idle();
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_data   = vb;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_data = vc;
        wait_ov(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(rdy_w[0]), 32'd0);
            chk("stall_data", 32'(od_w[0]), 32'(model(vb)));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_ov(0);
        chk("second_vec_data", 32'(od_w[0]), 32'(model(vc)));

        // reset in the middle of an evaluation
        wait_idle();
        send(vd);
        @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(busy_w[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        send(VEC_A);
        wait_ov(0);
        chk("post_reset_data", 32'(od_w[0]), 32'(RES_A));

        // back-to-back vectors with in_valid held high
        wait_idle();
        @(posedge clk);
        #1;
        in_data  = ve[0];
        in_valid = 1'b1;
        k = 0;
        t = 0;
        while (k < 3 && t < 60) begin
            @(negedge clk);
            t++;
            if (rdy_w[0]) begin
                acc[k] = cyc + 1;
                k++;
                @(posedge clk);
                #1;
                if (k < 3) in_data = ve[k];
                else       in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b_accepts", 32'(k), 32'd3);
        chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd6);
        chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd6);

        wait_idle();
        repeat (2) @(negedge clk);
        chk("sb_left0", 32'(g_mon[0].exp_q.size()), 32'd0);
        chk("sb_left1", 32'(g_mon[1].exp_q.size()), 32'd0);
        chk("sb_left2", 32'(g_mon[2].exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
